// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: baud-load sequencer, byte capture FIFO and frame watchdog
// for a receive-only UART core. Baud periods are pushed over the core's
// 8-bit load bus as a high/low strobe pair, only while the line is idle.
module uart_rx_ctrl #(
    parameter int          FIFO_DEPTH   = 8,
    parameter int          ADDR_W       = 3,
    parameter logic [15:0] BAUD_DEFAULT = 16'd433,
    parameter bit          WD_EN        = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_wr,
    input  logic [15:0]       cfg_baud,
    output logic              cfg_busy,
    input  logic              rx_serial_in,
    input  logic [7:0]        rx_data_in,
    input  logic              rx_avail_in,
    output logic [7:0]        rx_load_data_out,
    output logic              rx_baud_hi_out,
    output logic              rx_baud_lo_out,
    output logic              rd_valid,
    output logic [7:0]        rd_data,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    output logic              frame_timeout,
    input  logic              status_clr
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WAIT,
        LOAD_HI,
        LOAD_LO
    } loadState_t;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic [19:0]     WD_MAX     = 20'hFFFFF;

    loadState_t loadState;
    loadState_t nextState;

    logic [15:0] baudShadow;
    logic [15:0] baudActive;

    logic availD;
    logic availRise;
    logic frameActive;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] rdPtr;
    logic [ADDR_W:0]   fifoCount;
    logic              fifoFull;
    logic              push;
    logic              pop;
    logic              dropByte;

    logic [19:0] wdCount;
    logic [19:0] wdNext;
    logic [16:0] wdBase;
    logic [20:0] wdProduct;
    logic [19:0] wdLimit;
    logic        wdExpire;

    // ---------------------------------------------------------------
    // Edge detect, FIFO handshake and watchdog limit
    // ---------------------------------------------------------------
    assign availRise = rx_avail_in & ~availD;
    assign fifoFull  = (fifoCount == FULL_COUNT);
    assign rd_valid  = (fifoCount != '0);
    assign pop       = rd_valid & rd_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push      = availRise & (~fifoFull | pop);
    assign dropByte  = availRise & fifoFull & ~pop;
    assign rd_data   = rd_valid ? mem[rdPtr] : 8'h00;
    assign fifo_count = fifoCount;

    // 12*(b) built from shifts; the 21-bit sum cannot overflow for b <= 2^16.
    assign wdBase    = {1'b0, baudActive} + 17'd1;
    assign wdProduct = ({4'b0000, wdBase} << 3) + ({4'b0000, wdBase} << 2);
    assign wdLimit   = wdProduct[20] ? WD_MAX : wdProduct[19:0];
    assign wdNext    = wdCount + 20'd1;
    assign wdExpire  = WD_EN && frameActive && (wdNext >= wdLimit);

    assign cfg_busy = (loadState != IDLE);

    // Load FSM state register plus the shadow/active baud copies
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loadState  <= LOAD_WAIT;
            baudShadow <= BAUD_DEFAULT;
            baudActive <= BAUD_DEFAULT;
        end else begin
            loadState <= nextState;
            if (loadState == IDLE && cfg_wr) begin
                baudShadow <= cfg_baud;
            end
            if (loadState == LOAD_LO) begin
                baudActive <= baudShadow;
            end
        end
    end

    // Load FSM next-state and strobe decode
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        nextState        = loadState;
        rx_baud_hi_out   = 1'b0;
        rx_baud_lo_out   = 1'b0;
        rx_load_data_out = 8'h00;
        case (loadState)
            IDLE: begin
                if (cfg_wr) begin
                    nextState = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                if (!frameActive && rx_serial_in) begin
                    nextState = LOAD_HI;
                end
            end
            LOAD_HI: begin
                rx_baud_hi_out   = 1'b1;
                rx_load_data_out = baudShadow[15:8];
                // A start bit here pulls the core out of idle; retry the pair later.
                nextState = rx_serial_in ? LOAD_LO : LOAD_WAIT;
            end
            LOAD_LO: begin
                rx_baud_lo_out   = 1'b1;
                rx_load_data_out = baudShadow[7:0];
                nextState        = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Frame tracking: opens on a low line, closes on byte arrival or timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            availD      <= 1'b0;
            frameActive <= 1'b0;
            wdCount     <= '0;
        end else begin
            availD <= rx_avail_in;
            if (availRise || wdExpire) begin
                frameActive <= 1'b0;
            end else if (!frameActive && !rx_serial_in) begin
                frameActive <= 1'b1;
            end
            if (frameActive && !availRise && !wdExpire) begin
                wdCount <= wdNext;
            end else begin
                wdCount <= '0;
            end
        end
    end

    // FIFO storage write port
    // NOTE: the data array has no reset; only pointers and count do, and
    // rd_data is forced to zero while empty so stale contents never leak.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= rx_data_in;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + ADDR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + (ADDR_W + 1)'(1);
                2'b01:   fifoCount <= fifoCount - (ADDR_W + 1)'(1);
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    // Sticky status flags; a set in the same cycle wins over status_clr
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow      <= 1'b0;
            frame_timeout <= 1'b0;
        end else begin
            if (dropByte) begin
                overflow <= 1'b1;
            end else if (status_clr) begin
                overflow <= 1'b0;
            end
            if (wdExpire) begin
                frame_timeout <= 1'b1;
            end else if (status_clr) begin
                frame_timeout <= 1'b0;
            end
        end
    end

endmodule
